// File: rtl/sid_bridge_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the SPI-to-SID bridge.
// Optional statistics counters in sid_spi_bridge are enabled with SID_SPI_BRIDGE_STATS_EN.
package sid_bridge_pkg;

    localparam int SID_ADDR_W   = 5;
    localparam int SID_DATA_W   = 8;
    localparam int SID_CHIP_W   = 2;
    localparam int HDR_FLAG_BIT = 7;

    localparam logic [0:0] S_HDR = 1'b0;
    localparam logic [0:0] S_DAT = 1'b1;

    typedef struct packed {
        logic [SID_CHIP_W-1:0] chip;
        logic [SID_ADDR_W-1:0] addr;
        logic [SID_DATA_W-1:0] data;
    } sid_wr_t;

    localparam int SID_WR_W = $bits(sid_wr_t);

    function automatic logic chip_in_range(input logic [SID_CHIP_W-1:0] chip, input int num_sid);
        return 32'(chip) < num_sid;
    endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// Synchronous write FIFO; a push into a full FIFO is accepted only alongside a pop.
// FULL is registered from the post-edge occupancy; EMPTY is decoded from the count register.
module sid_wr_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sid_spi_bridge.sv
// Decodes SPI header/data byte pairs into SID register writes, issued at most one per CLKEN.
// SID_SPI_BRIDGE_STATS_EN adds saturating DROP_CNT/ERR_CNT counters.
module sid_spi_bridge
    import sid_bridge_pkg::*;
#(
    parameter int NUM_SID    = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [7:0]            SPI_DATA,
    input  logic                  SPI_RECV,
    input  logic                  SPI_CS_N,
    input  logic                  CLKEN,
    output logic [NUM_SID-1:0]    WR,
    output logic [SID_ADDR_W-1:0] ADDR,
    output logic [SID_DATA_W-1:0] DATAW,
    output logic                  FULL,
    output logic                  OVF,
    output logic                  ERR,
    output logic [0:0]            FSM_STATE
`ifdef SID_SPI_BRIDGE_STATS_EN
    ,
    output logic [15:0]           DROP_CNT,
    output logic [15:0]           ERR_CNT
`endif
);

    // Valid/ready: a decoded write is offered to the FIFO for one cycle (push); it is taken if
    // the FIFO is not full or pops on the same edge, otherwise it is dropped and OVF is raised.

    logic [0:0]            state;
    logic [SID_CHIP_W-1:0] hdr_chip;
    logic [SID_ADDR_W-1:0] hdr_addr;
    logic                  hdr_drop;

    logic                  byte_ok;
    logic                  is_hdr;
    logic [SID_CHIP_W-1:0] byte_chip;
    logic                  stray;
    logic                  bad_chip;
    logic                  err_evt;
    logic                  push;
    logic                  pop;
    logic                  ovf_evt;
    logic                  empty;
    sid_wr_t               wentry;
    sid_wr_t               rentry;
    logic [NUM_SID-1:0]    wr_onehot;

    assign byte_ok   = SPI_RECV && !SPI_CS_N;
    assign is_hdr    = SPI_DATA[HDR_FLAG_BIT];
    assign byte_chip = SPI_DATA[HDR_FLAG_BIT-1 -: SID_CHIP_W];
    assign stray     = byte_ok && (state == S_HDR) && !is_hdr;
    assign bad_chip  = byte_ok && (state == S_HDR) && is_hdr && !chip_in_range(byte_chip, NUM_SID);
    assign err_evt   = stray || bad_chip;
    assign push      = byte_ok && (state == S_DAT) && !hdr_drop;

    // The WR guard keeps strobes apart even if CLKEN is ever held high.
    assign pop       = CLKEN && !empty && (WR == '0);
    assign ovf_evt   = push && FULL && !pop;
    assign FSM_STATE = state;

    assign wentry.chip = hdr_chip;
    assign wentry.addr = hdr_addr;
    assign wentry.data = SPI_DATA;
    assign wr_onehot   = NUM_SID'(1) << rentry.chip;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_HDR;
            hdr_chip <= '0;
            hdr_addr <= '0;
            hdr_drop <= 1'b0;
        end else if (SPI_CS_N) begin
            state <= S_HDR;
        end else if (SPI_RECV) begin
            if (state == S_HDR) begin
                if (is_hdr) begin
                    state    <= S_DAT;
                    hdr_chip <= byte_chip;
                    hdr_addr <= SPI_DATA[SID_ADDR_W-1:0];
                    hdr_drop <= !chip_in_range(byte_chip, NUM_SID);
                end
            end else begin
                state <= S_HDR;
            end
        end
    end

    sid_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SID_WR_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (rentry),
        .full  (FULL),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WR    <= '0;
            ADDR  <= '0;
            DATAW <= '0;
            OVF   <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            WR <= pop ? wr_onehot : '0;
            if (pop) begin
                ADDR  <= rentry.addr;
                DATAW <= rentry.data;
            end
            if (ovf_evt) OVF <= 1'b1;
            if (err_evt) ERR <= 1'b1;
        end
    end

`ifdef SID_SPI_BRIDGE_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DROP_CNT <= '0;
            ERR_CNT  <= '0;
        end else begin
            if (ovf_evt && (DROP_CNT != 16'hFFFF)) DROP_CNT <= DROP_CNT + 16'd1;
            if (err_evt && (ERR_CNT != 16'hFFFF))  ERR_CNT  <= ERR_CNT + 16'd1;
        end
    end
`endif

endmodule
